// File: rtl/fifo_wr_pkg.sv
// Shared types and constants for the FIFO write-side packer.
// Optional stats counters are enabled with FIFO_WR_STATS_EN.
package fifo_wr_pkg;

  localparam int IN_W_DEF   = 8;
  localparam int DATA_W_DEF = 32;
  localparam int STAT_W     = 16;

  typedef struct packed {
    logic                  last;
    logic [DATA_W_DEF-1:0] data;
  } wr_entry_t;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_wr_packer_if.sv
// Beat stream plus FIFO write port of the write-side packer.
// master drives the stream and full flag; slave is the packer.
interface fifo_wr_packer_if
  import fifo_wr_pkg::*;
#(
  parameter int IN_WIDTH   = IN_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
);

  logic                  s_valid;
  logic                  s_ready;
  logic [IN_WIDTH-1:0]   s_data;
  logic                  s_last;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic                  pkt_done;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    output fifo_full,
    input  s_ready,
    input  fifo_wr_en,
    input  fifo_wdata,
    input  pkt_done
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    input  fifo_full,
    output s_ready,
    output fifo_wr_en,
    output fifo_wdata,
    output pkt_done
  );

endinterface

// File: rtl/fifo_wr_skid2.sv
// Two-entry word queue between the packer and the FIFO write port.
// Stats option (FIFO_WR_STATS_EN) does not affect this block.
module fifo_wr_skid2
  import fifo_wr_pkg::*;
(
  input  logic      wr_clk,
  input  logic      rst,
  input  logic      push,
  input  wr_entry_t push_entry,
  input  logic      pop,
  output logic [1:0] cnt,
  output wr_entry_t head
);

  wr_entry_t mem [2];
  logic      hptr;
  logic      tptr;

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      hptr   <= 1'b0;
      tptr   <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[tptr] <= push_entry;
        tptr      <= ~tptr;
      end
      if (pop) begin
        hptr <= ~hptr;
      end
      unique case (1'b1)
        push && !pop: cnt <= cnt + 2'd1;
        pop && !push: cnt <= cnt - 2'd1;
        default:      cnt <= cnt;
      endcase
    end
  end

  assign head = mem[hptr];

endmodule

// File: rtl/fifo_wr_packer.sv
// Packs IN_WIDTH beats little-endian into FIFO words via a 2-deep queue.
// Define FIFO_WR_STATS_EN to add saturating write/packet/stall counters.
module fifo_wr_packer
  import fifo_wr_pkg::*;
#(
  parameter int IN_WIDTH   = IN_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input  logic               wr_clk,
  input  logic               rst,
  fifo_wr_packer_if.slave    bus
`ifdef FIFO_WR_STATS_EN
  ,
  output logic [STAT_W-1:0]  words_written,
  output logic [STAT_W-1:0]  pkts_written,
  output logic [STAT_W-1:0]  stall_cycles
`endif
);

  localparam int RATIO = DATA_WIDTH / IN_WIDTH;
  localparam int LW    = $clog2(RATIO);
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  logic [LW-1:0]         lane;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_nxt;
  logic                  accept;
  logic                  close;
  logic                  wr_en;
  logic                  done_q;
  logic [1:0]            cnt;
  wr_entry_t             head;
  wr_entry_t             push_entry;

  // Ready depends only on queue occupancy, never on the FIFO flag.
  assign bus.s_ready = (cnt != 2'd2);
  assign accept      = bus.s_valid && bus.s_ready;
  assign close       = accept && (bus.s_last || lane == LAST_LANE);

  always_comb begin
    acc_nxt = acc;
    acc_nxt[lane*IN_WIDTH +: IN_WIDTH] = bus.s_data;
  end

  assign push_entry = '{last: bus.s_last, data: acc_nxt};

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      lane <= '0;
      acc  <= '0;
    end else if (accept) begin
      if (close) begin
        lane <= '0;
        acc  <= '0;
      end else begin
        lane <= lane + LW'(1);
        acc  <= acc_nxt;
      end
    end
  end

  fifo_wr_skid2 u_q (
    .wr_clk     (wr_clk),
    .rst        (rst),
    .push       (close),
    .push_entry (push_entry),
    .pop        (wr_en),
    .cnt        (cnt),
    .head       (head)
  );

  assign wr_en          = (cnt != 2'd0) && !bus.fifo_full;
  assign bus.fifo_wr_en = wr_en;
  assign bus.fifo_wdata = head.data;

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= wr_en && head.last;
    end
  end

  assign bus.pkt_done = done_q;

`ifdef FIFO_WR_STATS_EN
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      words_written <= '0;
      pkts_written  <= '0;
      stall_cycles  <= '0;
    end else begin
      if (wr_en) begin
        words_written <= sat_inc(words_written);
      end
      if (done_q) begin
        pkts_written <= sat_inc(pkts_written);
      end
      if (cnt != 2'd0 && bus.fifo_full) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
    end
  end
`endif

endmodule

// File: doc/fifo_wr_packer.md
Name: fifo_wr_packer

Overview:
Write-domain front end for the asynchronous FIFO. It accepts a narrow valid/ready byte stream with packet delimiters and packs IN_WIDTH beats into DATA_WIDTH words. It buffers completed words in a 2-entry queue and drives the FIFO write port (wr_en/wdata). It never writes while the FIFO reports full, so FIFO overflow cannot occur.

Parameters:
IN_WIDTH, 8, width of one input beat
DATA_WIDTH, 32, FIFO word width; must be an integer multiple of IN_WIDTH (ratio 2..8)
RATIO, DATA_WIDTH/IN_WIDTH, beats per word (derived, not overridden)

Ports:
wr_clk  input  1  write-domain clock; all logic on posedge
rst  input  1  reset, synchronous, active-high
s_valid  input  1  input beat valid
s_ready  output  1  block can accept a beat this cycle
s_data  input  IN_WIDTH  input beat
s_last  input  1  final beat of packet; closes the current word
fifo_full  input  1  FIFO full flag (write domain, may be combinational)
fifo_wr_en  output  1  FIFO write enable
fifo_wdata  output  DATA_WIDTH  FIFO write data
pkt_done  output  1  1-cycle pulse when a packet's final word is written to the FIFO

Behaviour:
- Beat is accepted on a posedge where s_valid && s_ready.
- Packing: lane counter lane_cnt runs 0..RATIO-1. An accepted beat lands in bits [lane_cnt*IN_WIDTH +: IN_WIDTH], so lane 0 is the LSB (little-endian).
- Word closes when an accepted beat has lane_cnt==RATIO-1 or s_last==1.
  - On close: the packed word, with all unfilled upper lanes forced to 0, plus a last-tag bit are pushed into the queue on the same edge.
  - lane_cnt returns to 0 and the accumulator clears.
- Queue: 2 entries, occupancy cnt 0..2, 1-bit head/tail pointers.
- s_ready = (cnt < 2). This is registered-state only, with no combinational path from fifo_full or s_valid. With cnt==2, s_ready stays 0 even if a pop occurs that cycle.
- fifo_wr_en = (cnt != 0) && !fifo_full, combinational. fifo_wdata = head entry data, held stable while stalled.
- Pop occurs on an edge with fifo_wr_en==1. A simultaneous push and pop leaves cnt unchanged.
- pkt_done is registered: high for 1 cycle after the edge that popped a last-tagged entry.
- Latency: a closing beat accepted at edge N gives fifo_wr_en=1 during cycle N+1 (FIFO not full and queue previously empty), so the word is written at edge N+1.
- Throughput: one word per RATIO accepted beats. A sustained full-rate stream is never back-pressured while the FIFO is not full.
- fifo_full high: wr_en stays 0 and the queue fills. Once the queue holds 2 entries, s_ready=0, and the partial accumulator holds its value.
- s_last with lane_cnt==0: the word carries only lane 0, upper lanes are 0.
- s_last together with lane_cnt==RATIO-1: a single close, with no extra empty word.
- Reset (any cycle, including mid-packet or mid-stall):
  - lane_cnt=0, accumulator=0, cnt=0, pointers=0.
  - Outputs: fifo_wr_en=0, fifo_wdata=0, pkt_done=0, s_ready=1 from the first cycle after reset.
  - Partial words are discarded.

Optional Feature:
FIFO_WR_STATS_EN
- Defined: adds outputs words_written[15:0], pkts_written[15:0] and stall_cycles[15:0]. All three reset to 0 and saturate at 16'hFFFF.
  - words_written increments on each fifo_wr_en.
  - pkts_written increments with each pkt_done.
  - stall_cycles increments each cycle with cnt!=0 && fifo_full.
- Undefined: the ports and counters do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Package fifo_wr_pkg holds:
  - default IN_WIDTH/DATA_WIDTH constants
  - a queue-entry struct typedef {logic last; logic [DATA_WIDTH-1:0] data}
  - the stats counter width constant (16)
- One sub-module: fifo_wr_skid2, the 2-entry queue with push/pop/cnt. The packer top instantiates it.

Test Plan:
- Reset then 8 beats 8'h01..8'h08 with s_last on beat 8, fifo_full=0 -> two writes, 32'h04030201 then 32'h08070605; pkt_done pulses once, one cycle after the second write.
- 3-beat packet AA,BB,CC with s_last on CC -> single write 32'h00CCBBAA.
- fifo_full=1 held while 12 beats are offered:
  - queue fills to 2, s_ready drops after the 8th accepted beat, fifo_wr_en stays 0.
  - Releasing full drains both words in order on consecutive cycles.
- Continuous stream with fifo_full toggling every 3 cycles -> output word sequence matches a reference model, no lost or duplicated words, fifo_wr_en never 1 while fifo_full=1.
- rst asserted after 2 beats of a word with 1 word queued -> queue and partial discarded, s_ready=1 next cycle, next packet's first word starts at lane 0.
- With FIFO_WR_STATS_EN: 5 packets of 4 beats plus 10 forced full cycles with data pending -> words_written=5, pkts_written=5, stall_cycles=10.
